// File: rtl/hazard_stall_unit_pkg.sv
// rv_pkg: shared RV32I pipeline definitions.
//   Opcode constants for the instruction classes the hazard logic cares
//   about, the memory-wait FSM state type, and helpers that classify an
//   opcode by which source registers it reads and whether it touches memory.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_LOAD)  || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_BRANCH) || (op == OP_IALU);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_STORE) || (op == OP_RTYPE) || (op == OP_BRANCH);
  endfunction

  function automatic logic is_load(input logic [6:0] op);
    return op == OP_LOAD;
  endfunction

  function automatic logic is_memop(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_mem_wait_timer.sv
// mem_wait_timer: counts consecutive cycles the pipeline is frozen on an
// outstanding data-memory access and raises a sticky timeout flag.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   pipe_freeze  pipeline is frozen waiting on data memory
//   dmem_ready   data memory completed the outstanding access
//   mem_timeout  sticky flag, set once MEM_TIMEOUT wait cycles have elapsed
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | no access outstanding, wcnt = 0
// ST_WAIT | frozen on memory, wcnt = frozen cycles so far (saturating)
module mem_wait_timer
  import rv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pipe_freeze,
  input  logic dmem_ready,
  output logic mem_timeout
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  wait_state_t      state;
  logic [CNT_W-1:0] wcnt;

  // The flag is set on the same edge that wcnt reaches MEM_TIMEOUT, so it
  // is visible together with the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (pipe_freeze) begin
            state <= ST_WAIT;
            wcnt  <= ONE;
            if (ONE == TMO) mem_timeout <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (dmem_ready) begin
            state <= ST_RUN;
            wcnt  <= '0;
          end else if (pipe_freeze && (wcnt != TMO)) begin
            wcnt <= wcnt + ONE;
            if ((wcnt + ONE) == TMO) mem_timeout <= 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
          wcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall, write-enable and flush generation for a 5-stage
// RV32I pipeline. Keeps shadow copies of the EX and MEM instruction state to
// detect load-use hazards, freezes the pipeline on outstanding data-memory
// accesses and flushes the front end on a taken branch.
// Ports:
//   clk, rst_n                     clock and asynchronous active-low reset
//   id_opcode/id_rs1/id_rs2/id_rd  fields of the instruction in ID
//   ex_branch_taken                branch in EX resolved taken
//   dmem_ready                     data memory finished the MEM access
//   stall                          bubble request to the control unit
//   pc_write, ifid_write           PC and IF/ID enables
//   ifid_flush, idex_flush         front-end flushes
//   pipe_freeze                    hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout                    sticky memory-wait timeout
module hazard_stall_unit
  import rv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       ex_branch_taken,
  input  logic       dmem_ready,
  output logic       stall,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       pipe_freeze,
  output logic       mem_timeout
);

  logic [4:0] ex_rd;
  logic       ex_memread;
  logic       ex_memop;
  logic       mem_memop;
  logic       lu;

  assign lu = ex_memread && (ex_rd != 5'd0) &&
              ((uses_rs1(id_opcode) && (id_rs1 == ex_rd)) ||
               (uses_rs2(id_opcode) && (id_rs2 == ex_rd)));

  // mem_memop is cleared asynchronously, so the freeze drops the moment
  // reset asserts.
  assign pipe_freeze = mem_memop && !dmem_ready;

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    stall      = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst_n) begin
      // hold the safe defaults while reset is asserted
    end else if (pipe_freeze) begin
      // a taken branch waits here; EX holds it until the freeze drops
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (ex_branch_taken) begin
      // the dependent ID instruction is discarded, so no load-use stall
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      stall      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd      <= '0;
      ex_memread <= 1'b0;
      ex_memop   <= 1'b0;
      mem_memop  <= 1'b0;
    end else if (!pipe_freeze) begin
      mem_memop <= ex_memop;
      if (idex_flush || stall) begin
        ex_rd      <= '0;
        ex_memread <= 1'b0;
        ex_memop   <= 1'b0;
      end else begin
        ex_rd      <= id_rd;
        ex_memread <= is_load(id_opcode);
        ex_memop   <= is_memop(id_opcode);
      end
    end
  end

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_mem_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_freeze(pipe_freeze),
    .dmem_ready (dmem_ready),
    .mem_timeout(mem_timeout)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed hazard scenarios with literal
// expectations plus randomized instruction streams, all checked every cycle
// against a behavioural model of the pipeline's EX/MEM occupancy.
module tb_hazard_stall_unit;

  localparam int TMO = 4;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] IALU   = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] NOP0   = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_branch_taken, dmem_ready;
  logic       stall, pc_write, ifid_write, ifid_flush, idex_flush;
  logic       pipe_freeze, mem_timeout;

  hazard_stall_unit #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_opcode      (id_opcode),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .ex_branch_taken(ex_branch_taken),
    .dmem_ready     (dmem_ready),
    .stall          (stall),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .pipe_freeze    (pipe_freeze),
    .mem_timeout    (mem_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: what instruction occupies EX, whether MEM holds a memory op,
  // how many consecutive cycles we've been frozen, and the sticky timeout
  logic [4:0] m_ex_rd;
  logic       m_ex_load, m_ex_mem, m_mem_mem, m_timeout;
  int         frozen_run;

  logic e_stall, e_pc, e_ifid_w, e_ifid_f, e_idex_f, e_freeze;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_rs1(input logic [6:0] op);
    case (op)
      LOAD, STORE, RTYPE, BRANCH, IALU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    case (op)
      STORE, RTYPE, BRANCH: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    m_ex_rd = 0; m_ex_load = 0; m_ex_mem = 0; m_mem_mem = 0;
    m_timeout = 0; frozen_run = 0;
  endtask

  task automatic model_eval();
    bit hazard;
    hazard = m_ex_load && (m_ex_rd != 0) &&
             ((reads_rs1(id_opcode) && id_rs1 == m_ex_rd) ||
              (reads_rs2(id_opcode) && id_rs2 == m_ex_rd));
    e_freeze = m_mem_mem && !dmem_ready;
    e_stall = 0; e_pc = 1; e_ifid_w = 1; e_ifid_f = 0; e_idex_f = 0;
    if (e_freeze) begin
      e_pc = 0; e_ifid_w = 0;
    end else if (ex_branch_taken) begin
      e_ifid_f = 1; e_idex_f = 1;
    end else if (hazard) begin
      e_stall = 1; e_pc = 0; e_ifid_w = 0;
    end
  endtask

  task automatic model_edge();
    if (!e_freeze) begin
      m_mem_mem = m_ex_mem;
      if (e_stall || e_idex_f) begin
        m_ex_rd = 0; m_ex_load = 0; m_ex_mem = 0;
      end else begin
        m_ex_rd   = id_rd;
        m_ex_load = (id_opcode == LOAD);
        m_ex_mem  = (id_opcode == LOAD) || (id_opcode == STORE);
      end
      frozen_run = 0;
    end else begin
      frozen_run++;
      if (frozen_run >= TMO) m_timeout = 1;
    end
  endtask

  task automatic compare_all();
    chk("stall", stall, e_stall);
    chk("pc_write", pc_write, e_pc);
    chk("ifid_write", ifid_write, e_ifid_w);
    chk("ifid_flush", ifid_flush, e_ifid_f);
    chk("idex_flush", idex_flush, e_idex_f);
    chk("pipe_freeze", pipe_freeze, e_freeze);
    chk("mem_timeout", mem_timeout, m_timeout);
  endtask

  // one pipeline cycle: advance the model across the edge, apply new ID
  // inputs, then check at the falling edge
  task automatic cyc(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic br, input logic rdy);
    @(posedge clk);
    model_edge();
    #1;
    id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    ex_branch_taken = br; dmem_ready = rdy;
    @(negedge clk);
    model_eval();
    compare_all();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    ex_branch_taken = 1'b1;
    #1;
    chk("rst_pipe_freeze", pipe_freeze, 1'b0);
    chk("rst_pc_write", pc_write, 1'b1);
    chk("rst_ifid_write", ifid_write, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_ifid_flush", ifid_flush, 1'b0);
    chk("rst_idex_flush", idex_flush, 1'b0);
    chk("rst_mem_timeout", mem_timeout, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    id_opcode = RTYPE; id_rs1 = 5'd5; id_rs2 = 5'd5; id_rd = 5'd3;
    ex_branch_taken = 1'b0; dmem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    model_eval();
    compare_all();
    chk("post_rst_no_hazard", stall, 1'b0);
  endtask

  logic [6:0] ops [8];
  logic       br_r, rdy_r;

  initial begin
    ops[0] = LOAD; ops[1] = STORE; ops[2] = RTYPE; ops[3] = BRANCH;
    ops[4] = IALU; ops[5] = LUI;   ops[6] = JAL;   ops[7] = LOAD;
    rst_n = 1'b0;
    id_opcode = NOP0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    ex_branch_taken = 0; dmem_ready = 1;
    model_clear();
    do_reset();

    // load-use: lw x5 ; add x6,x5,x7
    cyc(LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1);
    chk("lu_pre_stall", stall, 1'b0);
    cyc(RTYPE, 5'd5, 5'd7, 5'd6, 1'b0, 1'b1);
    chk("lu_stall", stall, 1'b1);
    chk("lu_pc_write", pc_write, 1'b0);
    chk("lu_ifid_write", ifid_write, 1'b0);
    cyc(RTYPE, 5'd5, 5'd7, 5'd6, 1'b0, 1'b1);
    chk("lu_once_stall", stall, 1'b0);
    chk("lu_once_pc_write", pc_write, 1'b1);

    // x0 guards and unused source
    cyc(LOAD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
    cyc(RTYPE, 5'd0, 5'd0, 5'd6, 1'b0, 1'b1);
    chk("x0_stall", stall, 1'b0);
    cyc(LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1);
    cyc(LUI, 5'd5, 5'd5, 5'd8, 1'b0, 1'b1);
    chk("lui_stall", stall, 1'b0);

    // taken branch beats load-use, and the flushed slot becomes a bubble
    cyc(LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1);
    cyc(LOAD, 5'd5, 5'd0, 5'd9, 1'b1, 1'b1);
    chk("br_ifid_flush", ifid_flush, 1'b1);
    chk("br_idex_flush", idex_flush, 1'b1);
    chk("br_stall", stall, 1'b0);
    chk("br_pc_write", pc_write, 1'b1);
    cyc(RTYPE, 5'd9, 5'd5, 5'd1, 1'b0, 1'b1);
    chk("br_bubble_stall", stall, 1'b0);

    // store held in MEM for 3 cycles
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cyc(STORE, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      chk("wait_freeze", pipe_freeze, 1'b1);
      chk("wait_pc_write", pc_write, 1'b0);
      chk("wait_no_flush", ifid_flush, 1'b0);
    end
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    chk("wait_release", pipe_freeze, 1'b0);
    chk("wait_deferred_flush", ifid_flush, 1'b1);
    chk("wait_no_timeout", mem_timeout, 1'b0);

    // randomized streams
    br_r = 0; rdy_r = 1;
    for (int n = 0; n < 400; n++) begin
      if (!e_freeze) br_r = ($urandom % 8) == 0;
      rdy_r = e_freeze ? (($urandom % 3) != 0) : (($urandom % 4) != 0);
      cyc(ops[$urandom % 8], 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8),
          br_r, rdy_r);
    end
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    do_reset();

    // timeout: 6 frozen cycles, flag appears after the 4th
    cyc(STORE, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("tmo_flag", mem_timeout, (k >= 5) ? 1'b1 : 1'b0);
    end
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("tmo_sticky", mem_timeout, 1'b1);
    chk("tmo_release", pipe_freeze, 1'b0);
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("tmo_sticky2", mem_timeout, 1'b1);

    // reset asserted in the middle of a wait
    cyc(STORE, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("midwait_frozen", pipe_freeze, 1'b1);
    do_reset();
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("after_rst_no_freeze", pipe_freeze, 1'b0);
    cyc(STORE, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc(NOP0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("after_rst_timeout_clear", mem_timeout, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Generates the `stall` signal consumed by the decode-stage control unit, plus the pipeline write-enable and flush signals for the 5-stage RV32I pipeline.
- Tracks shadow copies of the ID/EX and EX/MEM destination and memory-op state, so it detects load-use hazards internally.
- Freezes the whole pipeline while a data-memory access is outstanding.
- Flushes the front end on a taken branch resolved in EX.

Parameters:
- MEM_TIMEOUT, 16, number of consecutive wait cycles after which `mem_timeout` latches (minimum 1).
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_opcode  input  7  opcode of the instruction in ID.
- id_rs1  input  5  rs1 field of the ID instruction.
- id_rs2  input  5  rs2 field of the ID instruction.
- id_rd  input  5  rd field of the ID instruction.
- ex_branch_taken  input  1  branch in EX resolved taken; held stable by EX while frozen.
- dmem_ready  input  1  data memory has completed the access for the EX/MEM instruction.
- stall  output  1  to the control unit; forces the ID control word to a bubble.
- pc_write  output  1  PC register enable.
- ifid_write  output  1  IF/ID register enable.
- ifid_flush  output  1  clear IF/ID to NOP.
- idex_flush  output  1  clear ID/EX control to bubble.
- pipe_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
- mem_timeout  output  1  sticky error flag.

Behaviour:
- Opcode classes:
  - LOAD 0000011 uses rs1 and writes rd.
  - STORE 0100011 uses rs1 and rs2.
  - R-type 0110011 uses rs1 and rs2.
  - BRANCH 1100011 uses rs1 and rs2.
  - I-ALU 0010011 uses rs1.
  - Any other opcode uses no source register and is not a memory op.
- Shadow state:
  - `ex_rd[4:0]`, `ex_memread`, `ex_memop` describe the instruction in EX.
  - `mem_memop` describes the instruction in MEM.
- Shadow update, only when `pipe_freeze` = 0:
  - The EX shadow loads a bubble (all zero) if `idex_flush` or `stall` is asserted.
  - Otherwise the EX shadow loads {id_rd, LOAD, LOAD|STORE}.
  - `mem_memop` <= `ex_memop`.
- Load-use: `lu` = `ex_memread` & (`ex_rd` != 0) & ((uses_rs1 & `id_rs1` == `ex_rd`) | (uses_rs2 & `id_rs2` == `ex_rd`)).
- `pipe_freeze` = `mem_memop` & ~`dmem_ready`. It is combinational, so 0-cycle response to `dmem_ready`.
- Output priority (highest first):
  1. Freeze: `pc_write`=0, `ifid_write`=0, `stall`=0, flushes=0. A taken branch is deferred until freeze drops.
  2. Branch: `ex_branch_taken` gives `ifid_flush`=1, `idex_flush`=1, `pc_write`=1, `ifid_write`=1, `stall`=0. Flush overrides load-use because the dependent instruction is being discarded.
  3. Load-use: `stall`=1, `pc_write`=0, `ifid_write`=0. Exactly one bubble cycle per hazard, because the bubble clears `ex_memread`.
  4. Otherwise: `pc_write`=1, `ifid_write`=1, all other outputs 0.
- Wait FSM:
  - States are RUN and WAIT; the counter is `wcnt`.
  - RUN -> WAIT when `pipe_freeze`=1; `wcnt` <= 1.
  - WAIT -> RUN when `dmem_ready`=1; `wcnt` <= 0.
  - In WAIT, `wcnt` increments while frozen and saturates at MEM_TIMEOUT.
  - `mem_timeout` sets when `wcnt` == MEM_TIMEOUT and holds until reset. It does not alter the freeze.
- Reset (`rst_n`=0, asynchronous, including mid-WAIT):
  - All shadows and `wcnt` are cleared; FSM goes to RUN; `mem_timeout` is cleared.
  - While reset is held, outputs are forced to `pc_write`=1, `ifid_write`=1, all others 0.
  - After release, the first ID instruction sees no hazard.
- `id_rd`/`id_rs` == x0 never creates a hazard.
- Back-to-back loads feeding each other stall once per pair.

Decomposition:
- Shared package `rv_pkg`:
  - Opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_IALU.
  - FSM state enum {ST_RUN, ST_WAIT}.
  - Helper functions uses_rs1/uses_rs2.
- The control unit imports the same opcode constants.
- One sub-module, `mem_wait_timer`: contains the FSM, the saturating counter and the sticky timeout flag. Inputs are `pipe_freeze` and `dmem_ready`.

Test Plan:
- Load-use:
  - `lw x5` followed by `add x6,x5,x7` (`id_rs1`=5) -> `stall`=1, `pc_write`=0, `ifid_write`=0 for exactly 1 cycle.
  - Then `stall`=0 with the same ID operands held.
- x0 guard:
  - `lw x0` followed by `add` with `rs1`=0 -> `stall` stays 0.
  - `lw x5` followed by `lui` with `rs1` field=5 -> `stall` stays 0 (unused source).
- Branch vs load-use:
  - `ex_branch_taken`=1 in the same cycle as a load-use match -> `ifid_flush`=`idex_flush`=1, `stall`=0.
  - Next cycle the EX shadow is a bubble.
- Memory wait:
  - `sw` reaches MEM with `dmem_ready`=0 for 3 cycles -> `pipe_freeze`=1, `pc_write`=0 for 3 cycles.
  - Release happens the same cycle `dmem_ready`=1; `mem_timeout` stays 0.
- Timeout:
  - MEM_TIMEOUT=4, `dmem_ready` held 0 for 6 cycles -> `mem_timeout` rises after the 4th wait cycle.
  - Flag stays 1 after `dmem_ready`=1 and clears only on `rst_n`=0.
- Reset mid-WAIT:
  - Assert `rst_n`=0 asynchronously during freeze -> `pipe_freeze`=0, `pc_write`=1 immediately.
  - After release, the FSM is in RUN and `wcnt`=0.
